// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 encodings, master FSM states and per-beat
// strobe / address / legality helpers shared by axi4_cmd_master.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_PROTO   = 2'b10;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_CHK   = 4'd1;
    localparam logic [3:0] ST_AW    = 4'd2;
    localparam logic [3:0] ST_AR    = 4'd3;
    localparam logic [3:0] ST_WDAT  = 4'd4;
    localparam logic [3:0] ST_BRSP  = 4'd5;
    localparam logic [3:0] ST_RDAT  = 4'd6;
    localparam logic [3:0] ST_STS   = 4'd7;
    localparam logic [3:0] ST_DRAIN = 4'd8;

    // Byte lanes used by one beat; low lanes below an unaligned
    // start address are masked off.
    function automatic logic [15:0] beat_strb(
        input logic [11:0] addr,
        input logic [2:0]  size,
        input int unsigned strb_wid
    );
        logic [31:0] nb;
        logic [31:0] lanes;
        logic [31:0] off;
        nb    = 32'd1 << size;
        lanes = (32'd1 << nb) - 32'd1;
        off   = {20'd0, addr} & (strb_wid - 32'd1)
              & ~(nb - 32'd1);
        return 16'(lanes << off);
    endfunction

    // Only the low 12 bits move: legal INCR bursts never
    // cross a 4KB page.
    function automatic logic [11:0] next_lo(
        input logic [11:0] addr,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [11:0] nb;
        nb = 12'd1 << size;
        if (burst == BURST_FIXED) return addr;
        return (addr & ~(nb - 12'd1)) + nb;
    endfunction

    // Bursts this master refuses to put on the bus.
    function automatic logic burst_bad(
        input logic [11:0] addr,
        input logic [31:0] len,
        input logic [2:0]  size,
        input logic [1:0]  burst,
        input int unsigned max_size
    );
        logic [31:0] span;
        span = (len + 32'd1) << size;
        if (32'(size) > max_size) return 1'b1;
        if (burst == BURST_WRAP) return 1'b1;
        if (burst == 2'b11) return 1'b1;
        return (burst == BURST_INCR)
            && (({20'd0, addr} + span) > 32'd4096);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter;
// a push is accepted when full if a pop happens the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q;
    logic [AW-1:0]    rp_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rp_q];

    // Storage array, written on every accepted push.
    always_ff @(posedge ACLK) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

    // Pointers and occupancy; reset discards all entries.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/axi4_cmd_master.sv
// axi4_cmd_master: queues commands, runs one AXI4 burst at a
// time, streams data and returns one status per command.
module axi4_cmd_master
    import axi4_pkg::*;
#(
    parameter  int DATA_WID  = 64,
    parameter  int ADR_WID   = 32,
    parameter  int ID_WID    = 4,
    parameter  int LEN_WID   = 8,
    parameter  int CMD_DEPTH = 4,
    localparam int STRB_WID  = DATA_WID / 8
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_WID-1:0]   cmd_id,
    input  logic [ADR_WID-1:0]  cmd_addr,
    input  logic [LEN_WID-1:0]  cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic                wdat_valid,
    output logic                wdat_ready,
    input  logic [DATA_WID-1:0] wdat_data,
    output logic                rdat_valid,
    input  logic                rdat_ready,
    output logic [DATA_WID-1:0] rdat_data,
    output logic                rdat_last,
    output logic                sts_valid,
    input  logic                sts_ready,
    output logic [ID_WID-1:0]   sts_id,
    output logic                sts_write,
    output logic [1:0]          sts_resp,
    output logic [1:0]          sts_err,
    output logic                busy,
    output logic [ID_WID-1:0]   AWID,
    output logic [ADR_WID-1:0]  AWADDR,
    output logic [LEN_WID-1:0]  AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_WID-1:0] WDATA,
    output logic [STRB_WID-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [ID_WID-1:0]   BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ID_WID-1:0]   ARID,
    output logic [ADR_WID-1:0]  ARADDR,
    output logic [LEN_WID-1:0]  ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARLOCK,
    output logic [3:0]          ARCACHE,
    output logic [2:0]          ARPROT,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [ID_WID-1:0]   RID,
    input  logic [DATA_WID-1:0] RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);
    localparam int STRB_LOG2 = $clog2(STRB_WID);
    localparam int CMD_W = ID_WID + ADR_WID + LEN_WID + 6;

    logic [CMD_W-1:0]   fifo_din;
    logic [CMD_W-1:0]   fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    logic               f_write;
    logic [ID_WID-1:0]  f_id;
    logic [ADR_WID-1:0] f_addr;
    logic [LEN_WID-1:0] f_len;
    logic [2:0]         f_size;
    logic [1:0]         f_burst;

    logic [3:0]         state_q, state_d;
    logic               wr_q, wr_d;
    logic [ID_WID-1:0]  id_q, id_d;
    logic [ADR_WID-1:0] addr_q, addr_d;
    logic [LEN_WID-1:0] len_q, len_d;
    logic [2:0]         size_q, size_d;
    logic [1:0]         burst_q, burst_d;
    logic [LEN_WID:0]   beat_q, beat_d;
    logic [1:0]         resp_q, resp_d;
    logic [1:0]         err_q, err_d;

    logic               last_beat;
    logic               bad_cmd;
    logic               w_hs;
    logic               r_hs;

    assign fifo_din = {cmd_write, cmd_id, cmd_addr,
                       cmd_len, cmd_size, cmd_burst};
    assign {f_write, f_id, f_addr,
            f_len, f_size, f_burst} = fifo_dout;
    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push_i  (cmd_valid && cmd_ready),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign last_beat = (beat_q == {1'b0, len_q});
    assign bad_cmd   = burst_bad(addr_q[11:0], 32'(len_q),
                                 size_q, burst_q, STRB_LOG2);
    assign w_hs = (state_q == ST_WDAT) && wdat_valid && WREADY;
    assign r_hs = (state_q == ST_RDAT) && RVALID && rdat_ready;

    // Next-state and bookkeeping for the single outstanding burst.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        resp_d  = resp_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    wr_d    = f_write;
                    id_d    = f_id;
                    addr_d  = f_addr;
                    len_d   = f_len;
                    size_d  = f_size;
                    burst_d = f_burst;
                    beat_d  = '0;
                    resp_d  = RESP_OKAY;
                    err_d   = ERR_NONE;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (bad_cmd) begin
                    resp_d  = RESP_SLVERR;
                    err_d   = ERR_ILLEGAL;
                    state_d = wr_q ? ST_DRAIN : ST_STS;
                end else begin
                    state_d = wr_q ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                if (AWREADY) state_d = ST_WDAT;
            end
            ST_AR: begin
                if (ARREADY) state_d = ST_RDAT;
            end
            ST_WDAT: begin
                if (w_hs) begin
                    beat_d = beat_q + 1'b1;
                    addr_d = {addr_q[ADR_WID-1:12],
                              next_lo(addr_q[11:0],
                                      size_q, burst_q)};
                    if (last_beat) state_d = ST_BRSP;
                end
            end
            ST_BRSP: begin
                if (BVALID) begin
                    resp_d = BRESP;
                    if (BID != id_q) err_d = ERR_PROTO;
                    state_d = ST_STS;
                end
            end
            ST_RDAT: begin
                if (r_hs) begin
                    beat_d = beat_q + 1'b1;
                    if (RRESP > resp_q) resp_d = RRESP;
                    if ((RLAST != last_beat) || (RID != id_q))
                        err_d = ERR_PROTO;
                    if (RLAST) state_d = ST_STS;
                end
            end
            ST_DRAIN: begin
                if (wdat_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) state_d = ST_STS;
                end
            end
            ST_STS: begin
                if (sts_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered command context; reset abandons any burst.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            resp_q  <= RESP_OKAY;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != ST_IDLE) || !fifo_empty;

    assign AWID    = id_q;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = size_q;
    assign AWBURST = burst_q;
    assign AWLOCK  = 1'b0;
    assign AWCACHE = 4'b0011;
    assign AWPROT  = 3'b000;
    assign AWVALID = (state_q == ST_AW);

    assign ARID    = id_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = size_q;
    assign ARBURST = burst_q;
    assign ARLOCK  = 1'b0;
    assign ARCACHE = 4'b0011;
    assign ARPROT  = 3'b000;
    assign ARVALID = (state_q == ST_AR);

    assign WDATA  = wdat_data;
    assign WSTRB  = STRB_WID'(beat_strb(addr_q[11:0],
                                        size_q, STRB_WID));
    assign WLAST  = (state_q == ST_WDAT) && last_beat;
    assign WVALID = (state_q == ST_WDAT) && wdat_valid;
    assign wdat_ready = ((state_q == ST_WDAT) && WREADY)
                     || (state_q == ST_DRAIN);

    assign BREADY = (state_q == ST_BRSP);

    assign RREADY     = (state_q == ST_RDAT) && rdat_ready;
    assign rdat_valid = (state_q == ST_RDAT) && RVALID;
    assign rdat_data  = RDATA;
    assign rdat_last  = RLAST;

    assign sts_valid = (state_q == ST_STS);
    assign sts_id    = id_q;
    assign sts_write = wr_q;
    assign sts_resp  = resp_q;
    assign sts_err   = err_q;

endmodule

// File: tb/tb_axi4_cmd_master.sv
// tb_axi4_cmd_master: directed bench for axi4_cmd_master with
// hand-computed expectations and immediate-assertion checks.
module tb_axi4_cmd_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        wdat_valid, wdat_ready;
    logic [63:0] wdat_data;
    logic        rdat_valid, rdat_ready, rdat_last;
    logic [63:0] rdat_data;
    logic        sts_valid, sts_ready, sts_write;
    logic [3:0]  sts_id;
    logic [1:0]  sts_resp, sts_err;
    logic        busy;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWLOCK, ARLOCK;
    logic [3:0]  AWCACHE, ARCACHE;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic        BVALID, BREADY;
    logic        RLAST, RVALID, RREADY;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 ACLK = ~ACLK;

    axi4_cmd_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready),
        .wdat_data(wdat_data),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready),
        .rdat_data(rdat_data), .rdat_last(rdat_last),
        .sts_valid(sts_valid), .sts_ready(sts_ready),
        .sts_id(sts_id), .sts_write(sts_write),
        .sts_resp(sts_resp), .sts_err(sts_err),
        .busy(busy),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWLOCK(AWLOCK),
        .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
        .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK),
        .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic check(input string tag,
                         input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        @(negedge ACLK);
        #1;
    endtask

    task automatic push_cmd(input logic w, input logic [3:0] id,
                            input logic [31:0] a,
                            input logic [7:0] l,
                            input logic [2:0] s,
                            input logic [1:0] b);
        cmd_valid = 1'b1; cmd_write = w; cmd_id = id;
        cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
        #1;
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        tick();
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic wait_aw();
        for (int i = 0; i < 20 && !AWVALID; i++) tick();
        check("aw_wait", AWVALID, 1'b1);
    endtask

    task automatic wait_sts();
        for (int i = 0; i < 40 && !sts_valid; i++) tick();
        check("sts_wait", sts_valid, 1'b1);
    endtask

    task automatic ack_sts();
        sts_ready = 1'b1;
        tick();
        sts_ready = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        logic seen;
        logic [3:0] cur;

        ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_id = '0; cmd_addr = '0; cmd_len = '0;
        cmd_size = '0; cmd_burst = '0;
        wdat_valid = 1'b0; wdat_data = '0;
        rdat_ready = 1'b0; sts_ready = 1'b0;
        AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
        BID = '0; BRESP = '0; BVALID = 1'b0;
        RID = '0; RDATA = '0; RRESP = '0;
        RLAST = 1'b0; RVALID = 1'b0;

        // reset state
        tick(); tick();
        check("rst_valids",
              {AWVALID, WVALID, ARVALID, BREADY, RREADY,
               rdat_valid, wdat_ready, sts_valid, busy}, 9'd0);
        check("rst_sts", {sts_id, sts_write, sts_resp, sts_err},
              9'd0);
        ARESETn = 1'b1;
        tick();
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // full-width INCR write, 4 beats
        push_cmd(1'b1, 4'd3, 32'h100, 8'd3, 3'd3, 2'b01);
        check("wr1_busy", busy, 1'b1);
        wait_aw();
        check("wr1_aw", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST},
              {4'd3, 32'h100, 8'd3, 3'd3, 2'b01});
        check("wr1_aw_attr", {AWLOCK, AWCACHE, AWPROT},
              {1'b0, 4'b0011, 3'b000});
        wdat_valid = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            wdat_data = 64'h1111_0000 + 64'(b);
            #1;
            check("wr1_beat",
                  {WVALID, WSTRB, WLAST, WDATA},
                  {1'b1, 8'hFF, (b == 3), 64'h1111_0000 + 64'(b)});
            tick();
        end
        wdat_valid = 1'b0;
        check("wr1_bready", {BREADY, WVALID}, 2'b10);
        BVALID = 1'b1; BID = 4'd3; BRESP = 2'b00;
        tick();
        BVALID = 1'b0;
        check("wr1_sts",
              {sts_valid, sts_write, sts_id, sts_resp, sts_err},
              {1'b1, 1'b1, 4'd3, 2'd0, 2'd0});
        ack_sts();
        check("wr1_idle", busy, 1'b0);

        // narrow unaligned write; wrong BID flags a protocol error
        push_cmd(1'b1, 4'd5, 32'h102, 8'd1, 3'd1, 2'b01);
        wait_aw();
        check("wr2_awaddr", AWADDR, 32'h102);
        wdat_valid = 1'b1;
        tick();
        check("wr2_b0", {WVALID, WSTRB, WLAST}, {1'b1, 8'h0C, 1'b0});
        tick();
        check("wr2_b1", {WVALID, WSTRB, WLAST}, {1'b1, 8'h30, 1'b1});
        tick();
        wdat_valid = 1'b0;
        BVALID = 1'b1; BID = 4'd6; BRESP = 2'b00;
        #1;
        check("wr2_bready", BREADY, 1'b1);
        tick();
        BVALID = 1'b0;
        check("wr2_sts", {sts_valid, sts_id, sts_resp, sts_err},
              {1'b1, 4'd5, 2'd0, 2'b10});
        ack_sts();

        // read crossing 4KB is rejected without bus activity
        push_cmd(1'b0, 4'd7, 32'hFF8, 8'd1, 3'd3, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 20 && !sts_valid; i++) begin
            seen = seen | ARVALID | AWVALID;
            tick();
        end
        check("rej_rd_noaxi", seen, 1'b0);
        check("rej_rd_sts",
              {sts_valid, sts_write, sts_id, sts_resp, sts_err},
              {1'b1, 1'b0, 4'd7, 2'd2, 2'b01});
        ack_sts();

        // oversize write is rejected and drains len+1 beats
        wdat_valid = 1'b1;
        push_cmd(1'b1, 4'd2, 32'h0, 8'd2, 3'd4, 2'b01);
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !sts_valid; i++) begin
            seen = seen | AWVALID | WVALID;
            if (wdat_ready) n++;
            tick();
        end
        wdat_valid = 1'b0;
        check("rej_wr_drain", n, 3);
        check("rej_wr_noaxi", seen, 1'b0);
        check("rej_wr_sts",
              {sts_valid, sts_write, sts_id, sts_resp, sts_err},
              {1'b1, 1'b1, 4'd2, 2'd2, 2'b01});
        ack_sts();

        // 8-beat read ending exactly at 4KB, backpressured
        push_cmd(1'b0, 4'd9, 32'hFC0, 8'd7, 3'd3, 2'b01);
        for (int i = 0; i < 20 && !ARVALID; i++) tick();
        check("rd_ar", {ARVALID, ARID, ARADDR, ARLEN, ARCACHE},
              {1'b1, 4'd9, 32'hFC0, 8'd7, 4'b0011});
        tick();
        k = 0;
        RVALID = 1'b1; RID = 4'd9;
        for (int c = 0; c < 60 && k < 8; c++) begin
            rdat_ready = (c % 2) == 1;
            RDATA = 64'hA0 + 64'(k);
            RRESP = (k == 5) ? 2'd2 : 2'd0;
            RLAST = (k == 7);
            #1;
            if (c == 0) check("rd_bp", RREADY, 1'b0);
            if (rdat_ready) begin
                check("rd_beat",
                      {rdat_valid, RREADY, rdat_last, rdat_data},
                      {1'b1, 1'b1, (k == 7), 64'hA0 + 64'(k)});
                k++;
            end
            tick();
        end
        RVALID = 1'b0; RLAST = 1'b0; rdat_ready = 1'b0;
        #1;
        check("rd_beats", k, 8);
        check("rd_sts",
              {sts_valid, sts_write, sts_id, sts_resp, sts_err},
              {1'b1, 1'b0, 4'd9, 2'd2, 2'd0});
        ack_sts();

        // fill the FIFO behind a stalled AW, then drain in order
        AWREADY = 1'b0;
        for (int i = 1; i <= 4; i++)
            push_cmd(1'b1, 4'(i), 32'(i * 8), 8'd0, 3'd3, 2'b01);
        check("fill_ready4", cmd_ready, 1'b1);
        push_cmd(1'b1, 4'd5, 32'h28, 8'd0, 3'd3, 2'b01);
        check("fill_ready5", cmd_ready, 1'b0);
        check("fill_aw_held", {AWVALID, AWID}, {1'b1, 4'd1});
        AWREADY = 1'b1; wdat_valid = 1'b1; sts_ready = 1'b1;
        BVALID = 1'b1; BRESP = 2'b00;
        cur = '0;
        k = 0;
        for (int c = 0; c < 200 && k < 5; c++) begin
            if (AWVALID) cur = AWID;
            BID = cur;
            #1;
            if (sts_valid) begin
                check("order_sts", {sts_id, sts_err, sts_resp},
                      {4'(k + 1), 2'd0, 2'd0});
                k++;
            end
            tick();
        end
        check("order_count", k, 5);
        BVALID = 1'b0; wdat_valid = 1'b0; sts_ready = 1'b0;
        tick();
        check("order_idle", busy, 1'b0);

        // reset during the second write beat drops everything
        push_cmd(1'b1, 4'd6, 32'h0, 8'd3, 3'd3, 2'b01);
        push_cmd(1'b0, 4'd8, 32'h40, 8'd0, 3'd3, 2'b01);
        wdat_valid = 1'b1;
        wait_aw();
        tick();
        tick();
        check("mid_beat2", {WVALID, WLAST}, 2'b10);
        ARESETn = 1'b0;
        tick();
        check("mid_rst",
              {AWVALID, WVALID, ARVALID, BREADY, RREADY,
               rdat_valid, wdat_ready, sts_valid, busy}, 9'd0);
        ARESETn = 1'b1;
        wdat_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | ARVALID | AWVALID | busy;
        end
        check("mid_dropped", seen, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
